// File: rtl/spart_tx.sv
// SPART transmitter: one-entry holding register feeding an 8N1 shift register,
// bit timing taken from the oversampled rate_en tick of the baud-rate generator.
module spart_tx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] bus2tx,
    input  logic       rate_en,
    output logic       txd,
    output logic       tbr
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_n;
    logic [DATA_BITS-1:0]   hold, shift, shift_n;
    logic                   hold_full, hold_full_n;
    logic [BW-1:0]          bit_idx, bit_n;
    logic [TW-1:0]          tick, tick_n;
    logic                   txd_n;
    logic                   wr, load, bit_done;

    // A write only lands when the holding register is empty; otherwise it is dropped.
    assign wr       = iocs && !iorw && (ioaddr == 2'b00) && !hold_full;
    assign bit_done = rate_en && (tick == TW'(OVERSAMPLE - 1));
    assign tbr      = !hold_full;

    always_comb begin
        state_n     = state;
        shift_n     = shift;
        bit_n       = bit_idx;
        tick_n      = rate_en ? tick + 1'b1 : tick;
        hold_full_n = hold_full;
        load        = 1'b0;
        txd_n       = 1'b1;
        case (state)
            IDLE: begin
                tick_n = '0;
                load   = hold_full;
            end
            START: begin
                if (bit_done) begin
                    state_n = DATA;
                    bit_n   = '0;
                    tick_n  = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    tick_n = '0;
                    if (bit_idx == BW'(DATA_BITS - 1)) begin
                        state_n = STOP;
                    end else begin
                        shift_n = shift >> 1;
                        bit_n   = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    tick_n = '0;
                    // Chain straight into the next start bit when a byte is waiting.
                    if (hold_full) load = 1'b1;
                    else           state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            shift_n     = hold;
            state_n     = START;
            tick_n      = '0;
            hold_full_n = 1'b0;
        end else if (wr) begin
            hold_full_n = 1'b1;
        end
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift     <= '0;
            bit_idx   <= '0;
            tick      <= '0;
            hold_full <= 1'b0;
            txd       <= 1'b1;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            bit_idx   <= bit_n;
            tick      <= tick_n;
            hold_full <= hold_full_n;
            txd       <= txd_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    hold <= '0;
        else if (wr) hold <= bus2tx[DATA_BITS-1:0];
    end
endmodule

// File: tb/tb_spart_tx.sv
// Randomised self-checking bench for spart_tx: a line-level receiver model
// decodes txd by counting rate_en ticks and compares against the bytes written.
module tb_spart_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iocs = 1'b0, iorw = 1'b1, rate_en = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] bus2tx = 8'h00;
    logic       txd, tbr;

    int vectors = 0, errors = 0;
    int frames = 0, last_gap = 1000, gap = 1000;
    int re_mode = 2;
    bit m_act = 0;
    logic [7:0] exp_q[$];

    spart_tx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .bus2tx(bus2tx), .rate_en(rate_en), .txd(txd), .tbr(tbr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // rate_en: 0 = tied high, 1 = every 4th cycle, 2 = random, 3 = held low
    initial begin
        int c4 = 0;
        forever begin
            @(posedge clk); #1;
            case (re_mode)
                0: rate_en = 1'b1;
                1: rate_en = (c4 % 4 == 0);
                2: rate_en = 1'($urandom_range(0, 1));
                default: rate_en = 1'b0;
            endcase
            c4++;
        end
    end

    // Receiver model: each bit is exactly 16 rate_en ticks, LSB first, 8N1.
    initial begin
        int m_bit = 0, m_cnt = 0;
        bit m_new = 0, m_bad = 0;
        logic m_val = 1'b1;
        logic [9:0] m_frame = '0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_act = 0; gap = 1000;
            end else if (!m_act) begin
                if (txd === 1'b0) begin
                    m_act = 1; m_bit = 0; m_cnt = 0; m_new = 1; m_bad = 0;
                    last_gap = gap;
                end else if (gap < 100000) begin
                    gap++;
                end
            end
            if (rst && m_act) begin
                if (m_new) begin m_val = txd; m_new = 0; end
                else if (txd !== m_val) m_bad = 1;
                if (m_bit == 9) gap++;
                if (rate_en) m_cnt++;
                if (m_cnt == 16) begin
                    m_frame[m_bit] = m_val;
                    m_bit++; m_cnt = 0; m_new = 1;
                    if (m_bit == 9) gap = 0;
                    if (m_bit == 10) begin
                        m_act = 0;
                        frames++;
                        chk("rx_stop", 32'(m_frame[9]), 32'd1);
                        chk("rx_stable", 32'(m_bad), 32'd0);
                        if (exp_q.size() == 0) chk("rx_unexpected", 32'(m_frame[8:1]), 32'hFFFF);
                        else begin
                            e = exp_q.pop_front();
                            chk("rx_byte", 32'(m_frame[8:1]), 32'(e));
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic bus_wr(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] d);
        iocs = cs; iorw = rw; ioaddr = a; bus2tx = d;
        step();
        iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00; bus2tx = 8'($urandom);
    endtask

    task automatic wait_tbr(input int bound);
        int n = 0;
        while (tbr !== 1'b1 && n < bound) begin step(); n++; end
        chk("tbr_wait", 32'(tbr), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (!(exp_q.size() == 0 && !m_act && tbr === 1'b1) && n < bound) begin step(); n++; end
        chk("idle_wait", 32'(n < bound), 32'd1);
    endtask

    initial begin
        int f0, errs, z, ch, kind;
        logic [9:0] fr;
        logic v;
        logic [7:0] d;
        // reset held with random inputs
        #1;
        for (int i = 0; i < 8; i++) begin
            iocs = 1'($urandom); iorw = 1'($urandom); ioaddr = 2'($urandom); bus2tx = 8'($urandom);
            step();
            chk("rst_txd", 32'(txd), 32'd1);
            chk("rst_tbr", 32'(tbr), 32'd1);
        end
        iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00;
        rst = 1'b1;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (txd !== 1'b1 || tbr !== 1'b1) errs++;
        end
        chk("post_rst_quiet", 32'(errs), 32'd0);
        chk("post_rst_frames", 32'(frames), 32'd0);

        // single frame 0xA5, rate_en tied high: exact waveform
        re_mode = 0; step(); step();
        exp_q.push_back(8'hA5);
        bus_wr(1, 0, 2'b00, 8'hA5);
        chk("a5_tbr_low", 32'(tbr), 32'd0);
        step();
        chk("a5_tbr_back", 32'(tbr), 32'd1);
        fr = {1'b1, 8'hA5, 1'b0};
        errs = 0;
        for (int i = 0; i < 160; i++) begin
            if (txd !== fr[i / 16]) errs++;
            step();
        end
        chk("a5_wave", 32'(errs), 32'd0);
        chk("a5_idle_after", 32'(txd), 32'd1);
        wait_idle(200);

        // back-to-back: stop bit of frame 1 runs straight into start of frame 2
        f0 = frames;
        exp_q.push_back(8'h55); exp_q.push_back(8'h0F);
        bus_wr(1, 0, 2'b00, 8'h55);
        wait_tbr(10);
        bus_wr(1, 0, 2'b00, 8'h0F);
        wait_idle(500);
        chk("b2b_frames", 32'(frames - f0), 32'd2);
        chk("b2b_gap", 32'(last_gap >= 16 && last_gap <= 17), 32'd1);

        // overflow: second write while buffer full is dropped
        f0 = frames;
        exp_q.push_back(8'h11);
        bus_wr(1, 0, 2'b00, 8'h11);
        bus_wr(1, 0, 2'b00, 8'h22);
        wait_idle(500);
        chk("ovf_frames", 32'(frames - f0), 32'd1);

        // decode: wrong address, read, no chip select
        f0 = frames;
        bus_wr(1, 0, 2'b01, 8'h77); chk("dec_addr_tbr", 32'(tbr), 32'd1);
        bus_wr(1, 1, 2'b00, 8'h77); chk("dec_read_tbr", 32'(tbr), 32'd1);
        bus_wr(0, 0, 2'b00, 8'h77); chk("dec_cs_tbr", 32'(tbr), 32'd1);
        errs = 0;
        for (int i = 0; i < 200; i++) begin step(); if (txd !== 1'b1) errs++; end
        chk("dec_quiet", 32'(errs), 32'd0);
        chk("dec_frames", 32'(frames - f0), 32'd0);

        // gated rate_en: one tick per 4 cycles -> 64-cycle bits
        re_mode = 1;
        exp_q.push_back(8'h80);
        bus_wr(1, 0, 2'b00, 8'h80);
        z = 0;
        while (txd !== 1'b0 && z < 100) begin step(); z++; end
        z = 0;
        while (txd === 1'b0 && z < 1000) begin step(); z++; end
        chk("gate_zero_run", 32'(z >= 509 && z <= 512), 32'd1);
        wait_idle(2000);

        // freeze mid-DATA with rate_en held low
        exp_q.push_back(8'h5A);
        bus_wr(1, 0, 2'b00, 8'h5A);
        repeat (150) step();
        re_mode = 3;
        step(); step();
        v = txd; ch = 0;
        for (int i = 0; i < 100; i++) begin step(); if (txd !== v) ch++; end
        chk("freeze_txd", 32'(ch), 32'd0);
        chk("freeze_active", 32'(m_act), 32'd1);
        re_mode = 1;
        wait_idle(2000);

        // async reset during data bit 3 drops the frame and the buffered byte
        re_mode = 0; step();
        exp_q.push_back(8'hFF);
        bus_wr(1, 0, 2'b00, 8'hFF);
        step();
        bus_wr(1, 0, 2'b00, 8'h33);
        chk("mrst_tbr_full", 32'(tbr), 32'd0);
        repeat (68) step();
        #2 rst = 1'b0;
        #1;
        chk("mrst_txd", 32'(txd), 32'd1);
        chk("mrst_tbr", 32'(tbr), 32'd1);
        exp_q.delete();
        step(); step(); step();
        rst = 1'b1;
        f0 = frames;
        exp_q.push_back(8'h3C);
        bus_wr(1, 0, 2'b00, 8'h3C);
        wait_idle(500);
        chk("mrst_recover_frames", 32'(frames - f0), 32'd1);

        // randomised traffic with random rate_en
        re_mode = 2;
        for (int t = 0; t < 24; t++) begin
            wait_tbr(4000);
            kind = $urandom_range(0, 4);
            d = 8'($urandom);
            case (kind)
                0, 1: begin exp_q.push_back(d); bus_wr(1, 0, 2'b00, d); end
                2:    bus_wr(1, 1, 2'b00, d);
                3:    bus_wr(1, 0, 2'($urandom_range(1, 3)), d);
                default: bus_wr(0, 0, 2'b00, d);
            endcase
            chk("rnd_tbr", 32'(tbr), (kind <= 1) ? 32'd0 : 32'd1);
            if (kind <= 1 && $urandom_range(0, 2) == 0) bus_wr(1, 0, 2'b00, 8'($urandom));
            repeat ($urandom_range(0, 40)) step();
        end
        wait_idle(5000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
